// File: rtl/seq_truth_table.sv
// Reprogrammable NIN-input truth-table gate with registered output and serial table load.
// Define SEQ_TT_FILTER_EN to add a HOLD-cycle persistence filter in front of out_o.
module seq_truth_table #(
   parameter int                  NIN     = 3,
   parameter logic [(2**NIN)-1:0] TT_INIT = 8'h34,
   parameter int                  HOLD    = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [NIN-1:0] in_i,
   input  logic           cfg_start_i,
   input  logic           cfg_valid_i,
   input  logic           cfg_bit_i,
   output logic           cfg_ready_o,
   output logic           cfg_done_o,
   output logic           out_o
);
   localparam int TTW = 2**NIN;
   localparam int CW  = $clog2(TTW) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   if (HOLD < 1) begin : g_bad_hold
      $error("HOLD must be >= 1");
   end

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TTW-1:0] shadow_q, shadow_d;
   logic [TTW-1:0] active_q, active_d;
   logic           out_q, out_d;
   logic           raw;

   // MSB holds row 0, so the row index is the bitwise inverse of the inputs.
   assign raw = active_q[~in_i];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start_i) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (cfg_start_i) begin
               cnt_d    = '0;
               shadow_d = '0;
            end else if (cfg_valid_i) begin
               shadow_d = {shadow_q[TTW-2:0], cfg_bit_i};
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CW'(TTW - 1)) state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            active_d = shadow_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= TT_INIT;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

`ifdef SEQ_TT_FILTER_EN
   localparam int HW = $clog2(HOLD) + 1;

   logic [HW-1:0] stab_q, stab_d;
   logic          raw_prev_q;

   // Count consecutive cycles of an unchanged raw that disagrees with out.
   always_comb begin
      out_d  = out_q;
      stab_d = '0;
      if ((raw != out_q) && (raw == raw_prev_q)) begin
         if (stab_q == HW'(HOLD - 1)) out_d  = raw;
         else                         stab_d = stab_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stab_q     <= '0;
         raw_prev_q <= 1'b0;
      end else begin
         stab_q     <= stab_d;
         raw_prev_q <= raw;
      end
   end
`else
   assign out_d = raw;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) out_q <= 1'b0;
      else       out_q <= out_d;
   end

   assign out_o       = out_q;
   assign cfg_ready_o = (state_q == S_LOAD);
   assign cfg_done_o  = (state_q == S_COMMIT);
endmodule

// File: tb/tb_seq_truth_table.sv
// Directed vector bench for seq_truth_table; filter scenarios run when SEQ_TT_FILTER_EN is defined.
module tb_seq_truth_table;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] in_v = 3'b000;
   logic       start = 1'b0, valid = 1'b0, cbit = 1'b0;
   logic       ready, done, out_v;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [2:0] in;
      logic       exp;
   } vec_t;

   seq_truth_table #(.NIN(3), .TT_INIT(8'h34), .HOLD(3)) dut (
      .clk_i(clk), .rst_i(rst), .in_i(in_v),
      .cfg_start_i(start), .cfg_valid_i(valid), .cfg_bit_i(cbit),
      .cfg_ready_o(ready), .cfg_done_o(done), .out_o(out_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v[], input string name);
      for (int i = 0; i < v.size(); i++) begin
         in_v = v[i].in;
         tick();
         check($sformatf("%s_in%b", name, v[i].in), out_v, v[i].exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #2;
      check("rst_out", out_v, 1'b0);
      check("rst_ready", ready, 1'b0);
      check("rst_done", done, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   // Pulse start, shift tt MSB-first (optional valid gaps), leave the DUT in COMMIT.
   task automatic load(input logic [7:0] tt, input bit gaps, input logic old_out);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i == 2 || i == 5 || i == 7)) begin
            valid = 1'b0;
            tick();
            check("gap_ready", ready, 1'b1);
            check("gap_done", done, 1'b0);
         end
         check("load_ready", ready, 1'b1);
         valid = 1'b1;
         cbit  = tt[7-i];
         tick();
         check("load_old_out", out_v, old_out);
      end
      valid = 1'b0;
      check("commit_done", done, 1'b1);
      check("commit_ready", ready, 1'b0);
   endtask

`ifndef SEQ_TT_FILTER_EN
   vec_t t1[], t2[], t5[];
`endif

   initial begin
`ifndef SEQ_TT_FILTER_EN
      t1 = '{'{3'b000, 1'b0}, '{3'b010, 1'b1}, '{3'b011, 1'b1}, '{3'b101, 1'b1},
             '{3'b110, 1'b0}, '{3'b111, 1'b0}, '{3'b001, 1'b0}, '{3'b100, 1'b0}};
      t2 = '{'{3'b000, 1'b1}, '{3'b111, 1'b1}, '{3'b010, 1'b0}, '{3'b100, 1'b0}};
      t5 = '{'{3'b000, 1'b0}, '{3'b010, 1'b1}, '{3'b100, 1'b0}};

      // Default table 8'h34
      do_reset();
      apply(t1, "tt34");

      // Load 8'h81; a start during COMMIT must be ignored
      in_v = 3'b010;
      tick();
      check("pre81_out", out_v, 1'b1);
      load(8'h81, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_commit_ready", ready, 1'b0);
      check("post_commit_done", done, 1'b0);
      apply(t2, "tt81");

      // Gapped load of 8'h5A over 8'h34; row 2 goes 1 -> 0 only after commit
      do_reset();
      in_v = 3'b010;
      tick();
      check("pre5a_out", out_v, 1'b1);
      load(8'h5A, 1'b1, 1'b1);
      tick();
      check("commit_edge_old_out", out_v, 1'b1);
      check("idle_done", done, 1'b0);
      tick();
      check("first_new_out", out_v, 1'b0);

      // Partial load of 5 bits, restart, then 8'hFF
      start = 1'b1;
      tick();
      start = 1'b0;
      valid = 1'b1;
      cbit  = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      valid = 1'b0;
      load(8'hFF, 1'b0, 1'b0);
      tick();
      for (int r = 0; r < 8; r++) begin
         in_v = 3'(r);
         tick();
         check($sformatf("ttff_row%0d", r), out_v, 1'b1);
      end

      // Reset in the middle of a load
      in_v  = 3'b000;
      start = 1'b1;
      tick();
      start = 1'b0;
      valid = 1'b1;
      cbit  = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      valid = 1'b0;
      check("midload_ready", ready, 1'b1);
      check("midload_old_out", out_v, 1'b1);
      rst = 1'b1;
      #1;
      check("midrst_ready", ready, 1'b0);
      check("midrst_out", out_v, 1'b0);
      tick();
      rst = 1'b0;
      apply(t5, "after_rst");
      check("after_rst_ready", ready, 1'b0);
`else
      // Persistence filter, HOLD=3, table 8'h34 (row 0 -> 0, row 2 -> 1)
      do_reset();
      in_v = 3'b000;
      tick();
      tick();
      in_v = 3'b010;
      tick();
      tick();
      in_v = 3'b000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pulse2_out", out_v, 1'b0);
      end
      in_v = 3'b010;
      tick();
      tick();
      tick();
      in_v = 3'b000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pulse3_out", out_v, 1'b0);
      end
      in_v = 3'b010;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stable_wait_out", out_v, 1'b0);
      end
      tick();
      check("stable_out", out_v, 1'b1);
      in_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fall_wait_out", out_v, 1'b1);
      end
      tick();
      check("fall_out", out_v, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
